// File: rtl/rr_port_allocator_if.sv
// Signal bundle between the five router input ports and one rr_port_allocator output.
// pkt_cnt is present only when PKT_CNT_EN is defined.
interface rr_port_allocator_if;
  logic [4:0]  req;
  logic [14:0] flit_id;
  logic        credit_return;
  logic [4:0]  grant;
  logic [2:0]  out_sel;
  logic        out_valid;
  logic        timeout;
  logic [3:0]  credit_cnt;
`ifdef PKT_CNT_EN
  logic [15:0] pkt_cnt;

  modport master (
    output req, flit_id, credit_return,
    input  grant, out_sel, out_valid, timeout, credit_cnt, pkt_cnt
  );

  modport slave (
    input  req, flit_id, credit_return,
    output grant, out_sel, out_valid, timeout, credit_cnt, pkt_cnt
  );
`else
  modport master (
    output req, flit_id, credit_return,
    input  grant, out_sel, out_valid, timeout, credit_cnt
  );

  modport slave (
    input  req, flit_id, credit_return,
    output grant, out_sel, out_valid, timeout, credit_cnt
  );
`endif
endinterface

// File: rtl/rr_port_allocator.sv
// Round-robin, packet-locked output-port allocator with credit tracking and a stall watchdog.
// Optional tail-packet counter (pkt_cnt) enabled by defining PKT_CNT_EN.
module rr_port_allocator #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input logic                clk,
  input logic                rst,
  rr_port_allocator_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [3:0]  DEPTH_C   = 4'(DEPTH);
  localparam logic [11:0] TIMEOUT_C = 12'(TIMEOUT);
  localparam logic [2:0]  SEL_IDLE  = 3'd7;

  // Requester index base+step, wrapped modulo five (base <= 4, step <= 5).
  function automatic logic [2:0] wrap5(input logic [2:0] base, input logic [2:0] step);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    return (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
  endfunction

  state_t      state_r, state_nxt_s;
  logic [4:0]  grant_r, grant_nxt_s;
  logic [2:0]  sel_r, sel_nxt_s;
  logic [2:0]  ptr_r, ptr_nxt_s;
  logic [3:0]  credit_r, credit_nxt_s;
  logic [11:0] wd_r, wd_nxt_s;
  logic [11:0] wd_inc_s;
  logic        timeout_r, timeout_nxt_s;
  logic [4:0]  elig_s;
  logic        req_g_s;
  logic        tail_g_s;
  logic        credit_ok_s;
  logic        xfer_s;
  logic        win_found_s;
  logic [2:0]  win_idx_s;
`ifdef PKT_CNT_EN
  logic [15:0] pkt_cnt_r;
`endif

  assign credit_ok_s = (credit_r != 4'd0);
  assign xfer_s      = (state_r == HOLD) & req_g_s & credit_ok_s;
  assign wd_inc_s    = wd_r + 12'd1;

  // Per-requester header eligibility plus the granted requester's req and tail bit.
  always_comb begin
    elig_s   = 5'b00000;
    req_g_s  = 1'b0;
    tail_g_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      elig_s[i] = bus.req[i] & bus.flit_id[3*i] & credit_ok_s;
      req_g_s   = req_g_s | (grant_r[i] & bus.req[i]);
      tail_g_s  = tail_g_s | (grant_r[i] & bus.flit_id[3*i+2]);
    end
  end

  // First eligible requester searching from ptr+1 around to ptr itself.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      if (!win_found_s && elig_s[wrap5(ptr_r, 3'(k))]) begin
        win_found_s = 1'b1;
        win_idx_s   = wrap5(ptr_r, 3'(k));
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Credit counter: a transfer consumes, a return refills up to DEPTH.
  always_comb begin
    credit_nxt_s = credit_r;
    case ({xfer_s, bus.credit_return})
      2'b10:   credit_nxt_s = credit_r - 4'd1;
      2'b01:   credit_nxt_s = (credit_r == DEPTH_C) ? credit_r : credit_r + 4'd1;
      default: credit_nxt_s = credit_r;
    endcase
  end

  // Next-state and next-output logic for the packet lock.
  always_comb begin
    state_nxt_s   = state_r;
    grant_nxt_s   = grant_r;
    sel_nxt_s     = sel_r;
    ptr_nxt_s     = ptr_r;
    wd_nxt_s      = wd_r;
    timeout_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_nxt_s = HOLD;
          grant_nxt_s = 5'b00001 << win_idx_s;
          sel_nxt_s   = win_idx_s;
          ptr_nxt_s   = win_idx_s;
          wd_nxt_s    = 12'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (xfer_s) begin
          wd_nxt_s = 12'd0;
          if (tail_g_s) begin
            state_nxt_s = IDLE;
            grant_nxt_s = 5'b00000;
            sel_nxt_s   = SEL_IDLE;
          end else begin
            state_nxt_s = HOLD;
          end
        end else if (wd_inc_s == TIMEOUT_C) begin
          // Stalled for TIMEOUT consecutive cycles: drop the lock.
          state_nxt_s   = IDLE;
          grant_nxt_s   = 5'b00000;
          sel_nxt_s     = SEL_IDLE;
          wd_nxt_s      = 12'd0;
          timeout_nxt_s = 1'b1;
        end else begin
          wd_nxt_s = wd_inc_s;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = 5'b00000;
        sel_nxt_s   = SEL_IDLE;
        wd_nxt_s    = 12'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      grant_r   <= 5'b00000;
      sel_r     <= SEL_IDLE;
      ptr_r     <= 3'd4;
      credit_r  <= DEPTH_C;
      wd_r      <= 12'd0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      grant_r   <= grant_nxt_s;
      sel_r     <= sel_nxt_s;
      ptr_r     <= ptr_nxt_s;
      credit_r  <= credit_nxt_s;
      wd_r      <= wd_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

`ifdef PKT_CNT_EN
  // Completed-packet counter; forced releases never reach a tail transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_r <= 16'd0;
    end else if (xfer_s && tail_g_s) begin
      pkt_cnt_r <= pkt_cnt_r + 16'd1;
    end else begin
      pkt_cnt_r <= pkt_cnt_r;
    end
  end

  assign bus.pkt_cnt = pkt_cnt_r;
`endif

  assign bus.grant      = grant_r;
  assign bus.out_sel    = sel_r;
  assign bus.out_valid  = xfer_s;
  assign bus.timeout    = timeout_r;
  assign bus.credit_cnt = credit_r;

endmodule

// File: tb/tb_rr_port_allocator.sv
// Directed self-checking bench for rr_port_allocator (DEPTH=4, TIMEOUT=8).
module tb_rr_port_allocator;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  rr_port_allocator_if bus ();

  rr_port_allocator #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] fid(input int i, input logic [2:0] t);
    logic [14:0] v;
    v = 15'(t) << (3 * i);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [4:0] r, input logic [14:0] f, input logic c);
    bus.req           = r;
    bus.flit_id       = f;
    bus.credit_return = c;
    #1;
  endtask

  // Drive one cycle of inputs, check all outputs in that cycle, advance one clock.
  task automatic step(input string tag, input logic [4:0] r, input logic [14:0] f,
                      input logic c, input logic [4:0] eg, input logic [2:0] esel,
                      input logic eov, input logic [3:0] ecc, input logic etmo);
    drive(r, f, c);
    chk({tag, ".grant"},   32'(bus.grant),      32'(eg));
    chk({tag, ".out_sel"}, 32'(bus.out_sel),    32'(esel));
    chk({tag, ".valid"},   32'(bus.out_valid),  32'(eov));
    chk({tag, ".credit"},  32'(bus.credit_cnt), 32'(ecc));
    chk({tag, ".timeout"}, 32'(bus.timeout),    32'(etmo));
    cyc();
  endtask

  localparam logic [14:0] HDR_ALL = 15'b101_101_101_101_101;

  logic [4:0] rr_grant [12];
  logic [2:0] rr_sel   [12];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rr_grant = '{5'd0, 5'd1, 5'd0, 5'd2, 5'd0, 5'd4, 5'd0, 5'd8, 5'd0, 5'd16, 5'd0, 5'd1};
    rr_sel   = '{3'd7, 3'd0, 3'd7, 3'd1, 3'd7, 3'd2, 3'd7, 3'd3, 3'd7, 3'd4, 3'd7, 3'd0};

    // Reset for two edges, then idle.
    rst = 1'b1;
    drive(5'd0, 15'd0, 1'b0);
    cyc();
    cyc();
    rst = 1'b0;
    step("reset", 5'd0, 15'd0, 1'b0, 5'd0, 3'd7, 1'b0, 4'd4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(5'd0, 15'd0, 1'b0);
      chk("idle.grant", 32'(bus.grant), 32'd0);
      cyc();
    end

    // Single three-flit packet from L, credits returned three cycles later.
    step("sp0", 5'b00001, fid(0, 3'b001), 1'b0, 5'b00000, 3'd7, 1'b0, 4'd4, 1'b0);
    step("sp1", 5'b00001, fid(0, 3'b001), 1'b0, 5'b00001, 3'd0, 1'b1, 4'd4, 1'b0);
    step("sp2", 5'b00001, fid(0, 3'b010), 1'b0, 5'b00001, 3'd0, 1'b1, 4'd3, 1'b0);
    step("sp3", 5'b00001, fid(0, 3'b100), 1'b0, 5'b00001, 3'd0, 1'b1, 4'd2, 1'b0);
    step("sp4", 5'b00000, 15'd0,          1'b1, 5'b00000, 3'd7, 1'b0, 4'd1, 1'b0);
    step("sp5", 5'b00000, 15'd0,          1'b1, 5'b00000, 3'd7, 1'b0, 4'd2, 1'b0);
    step("sp6", 5'b00000, 15'd0,          1'b1, 5'b00000, 3'd7, 1'b0, 4'd3, 1'b0);
    drive(5'd0, 15'd0, 1'b0);
    chk("sp7.credit", 32'(bus.credit_cnt), 32'd4);
`ifdef PKT_CNT_EN
    chk("sp7.pkt_cnt", 32'(bus.pkt_cnt), 32'd1);
`endif
    cyc();

    // Round robin among five single-flit requesters, pointer restored by reset.
    rst = 1'b1;
    drive(5'd0, 15'd0, 1'b0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(5'b11111, HDR_ALL, 1'b1);
      chk("rr.grant",  32'(bus.grant),      32'(rr_grant[c]));
      chk("rr.sel",    32'(bus.out_sel),    32'(rr_sel[c]));
      chk("rr.valid",  32'(bus.out_valid),  32'(rr_grant[c] != 5'd0));
      chk("rr.credit", 32'(bus.credit_cnt), 32'd4);
      cyc();
    end

    // Credit exhaustion: six-flit packet from E with no returns until stalled.
    step("ce0",  5'b00100, fid(2, 3'b001), 1'b0, 5'b00000, 3'd7, 1'b0, 4'd4, 1'b0);
`ifdef PKT_CNT_EN
    chk("rr.pkt_cnt", 32'(bus.pkt_cnt), 32'd6);
`endif
    step("ce1",  5'b00100, fid(2, 3'b001), 1'b0, 5'b00100, 3'd2, 1'b1, 4'd4, 1'b0);
    step("ce2",  5'b00100, fid(2, 3'b010), 1'b0, 5'b00100, 3'd2, 1'b1, 4'd3, 1'b0);
    step("ce3",  5'b00100, fid(2, 3'b010), 1'b0, 5'b00100, 3'd2, 1'b1, 4'd2, 1'b0);
    step("ce4",  5'b00100, fid(2, 3'b010), 1'b0, 5'b00100, 3'd2, 1'b1, 4'd1, 1'b0);
    step("ce5",  5'b00100, fid(2, 3'b010), 1'b0, 5'b00100, 3'd2, 1'b0, 4'd0, 1'b0);
    step("ce6",  5'b00100, fid(2, 3'b010), 1'b1, 5'b00100, 3'd2, 1'b0, 4'd0, 1'b0);
    step("ce7",  5'b00100, fid(2, 3'b010), 1'b0, 5'b00100, 3'd2, 1'b1, 4'd1, 1'b0);
    step("ce8",  5'b00100, fid(2, 3'b100), 1'b1, 5'b00100, 3'd2, 1'b0, 4'd0, 1'b0);
    step("ce9",  5'b00100, fid(2, 3'b100), 1'b0, 5'b00100, 3'd2, 1'b1, 4'd1, 1'b0);
    step("ce10", 5'b00000, 15'd0,          1'b1, 5'b00000, 3'd7, 1'b0, 4'd0, 1'b0);
    step("ce11", 5'b00000, 15'd0,          1'b1, 5'b00000, 3'd7, 1'b0, 4'd1, 1'b0);
    step("ce12", 5'b00000, 15'd0,          1'b1, 5'b00000, 3'd7, 1'b0, 4'd2, 1'b0);
    step("ce13", 5'b00000, 15'd0,          1'b1, 5'b00000, 3'd7, 1'b0, 4'd3, 1'b0);

    // Watchdog: W sends a header then stalls; S waits with a header meanwhile.
    step("to0", 5'b01000, fid(3, 3'b001), 1'b0, 5'b00000, 3'd7, 1'b0, 4'd4, 1'b0);
    step("to1", 5'b01000, fid(3, 3'b001), 1'b0, 5'b01000, 3'd3, 1'b1, 4'd4, 1'b0);
    for (int s = 0; s < 8; s++) begin
      step("to_stall", 5'b10000, fid(4, 3'b001), 1'b0, 5'b01000, 3'd3, 1'b0, 4'd3, 1'b0);
    end
    step("to_fire", 5'b10000, fid(4, 3'b001), 1'b0, 5'b00000, 3'd7, 1'b0, 4'd3, 1'b1);
    drive(5'b10000, fid(4, 3'b001), 1'b0);
    chk("to_next.grant",   32'(bus.grant),   32'b10000);
    chk("to_next.sel",     32'(bus.out_sel), 32'd4);
    chk("to_next.timeout", 32'(bus.timeout), 32'd0);
`ifdef PKT_CNT_EN
    chk("to_next.pkt_cnt", 32'(bus.pkt_cnt), 32'd7);
`endif
    cyc();

    // Reset mid-packet after a cycle with simultaneous transfer and credit return.
    rst = 1'b1;
    drive(5'd0, 15'd0, 1'b0);
    cyc();
    rst = 1'b0;
    step("mp0", 5'b00010, fid(1, 3'b001), 1'b0, 5'b00000, 3'd7, 1'b0, 4'd4, 1'b0);
    step("mp1", 5'b00010, fid(1, 3'b001), 1'b0, 5'b00010, 3'd1, 1'b1, 4'd4, 1'b0);
    step("mp2", 5'b00010, fid(1, 3'b010), 1'b0, 5'b00010, 3'd1, 1'b1, 4'd3, 1'b0);
    step("mp3", 5'b00010, fid(1, 3'b010), 1'b1, 5'b00010, 3'd1, 1'b1, 4'd2, 1'b0);
    rst = 1'b1;
    step("mp4", 5'b00010, fid(1, 3'b010), 1'b0, 5'b00010, 3'd1, 1'b1, 4'd2, 1'b0);
    rst = 1'b0;
`ifdef PKT_CNT_EN
    drive(5'b00010, fid(1, 3'b010), 1'b0);
    chk("mp5.pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
`endif
    step("mp5", 5'b00010, fid(1, 3'b010), 1'b0, 5'b00000, 3'd7, 1'b0, 4'd4, 1'b0);
    step("mp6", 5'b00010, fid(1, 3'b010), 1'b0, 5'b00000, 3'd7, 1'b0, 4'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
